// File: rtl/sprite_fetch_sched.sv
// Per-line sprite graphics fetch in post-sort HBLANK, plus arbitration of the sprite RAM
// read port between the video fetch and CPU readback.
//   state | meaning
//   IDLE  | waiting for the post-sort column
//   ISSUE | video drives ram_addr for {slot, word}
//   WAIT  | RAM latency; port free for CPU; dvalid on the last cycle
//   DONE  | all slots fetched, waiting for the line to wrap
module sprite_fetch_sched #(
  parameter int NUM_SPRITES = 16,
  parameter int H_ACTIVE    = 640,
  parameter int SORT_TIME   = 64,
  parameter int H_TOTAL     = 800,
  parameter int RAM_LAT     = 2,
  parameter int ADDR_W      = 12,
  parameter int IDX_W       = $clog2(NUM_SPRITES + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [11:0]       pix_col,
  output logic [IDX_W-1:0]  sprite_index,
  output logic              sprite_word,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [1:0]        sprite_dvalid,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_rdata,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              fetch_busy,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int POST_SORT = H_ACTIVE + SORT_TIME;
  // pix_col is a free-running count, so decoding one column early puts the first
  // ISSUE on POST_SORT and lets all 32 words land before the line wraps.
  localparam int START_COL = (POST_SORT == 0) ? H_TOTAL - 1 : POST_SORT - 1;
  localparam int SLOT_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int WCNT_W    = $clog2(RAM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                word_q, word_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                overrun_q, overrun_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [RAM_LAT-1:0]  tag_q, tag_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic                line_wrap, start_hit, busy, ovr_set;

  assign line_wrap = (pix_col == 12'd0);
  assign start_hit = (pix_col == 12'(START_COL));
  assign busy      = (state_q == ISSUE) || (state_q == WAIT);

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    word_d        = word_q;
    wcnt_d        = wcnt_q;
    sprite_dvalid = 2'b00;
    ovr_set       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_hit) begin
          state_d = ISSUE;
          slot_d  = '0;
          word_d  = 1'b0;
        end else if (state_q == DONE && line_wrap) begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (line_wrap) begin
          ovr_set = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (line_wrap) begin
          ovr_set = 1'b1;
          state_d = IDLE;
        end else if (wcnt_q == WCNT_W'(RAM_LAT)) begin
          sprite_dvalid[word_q] = 1'b1;
          if (!word_q) begin
            word_d  = 1'b1;
            state_d = ISSUE;
          end else if (slot_q == SLOT_W'(NUM_SPRITES - 1)) begin
            state_d = DONE;
          end else begin
            slot_d  = slot_q + 1'b1;
            word_d  = 1'b0;
            state_d = ISSUE;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Video owns the port only in ISSUE; otherwise a CPU grant takes it, else hold.
  assign cpu_gnt = cpu_req & (state_q != ISSUE);

  always_comb begin
    ram_addr_d = ram_addr_q;
    if (state_q == ISSUE) ram_addr_d = vid_addr;
    else if (cpu_gnt)     ram_addr_d = cpu_addr;
  end

  always_comb begin
    tag_d       = RAM_LAT'({tag_q, cpu_gnt});
    cpu_rdata_d = tag_q[RAM_LAT-1] ? ram_rdata : cpu_rdata_q;
    overrun_d   = overrun_q;
    if (ovr_set)          overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      word_q      <= 1'b0;
      wcnt_q      <= '0;
      overrun_q   <= 1'b0;
      ram_addr_q  <= '0;
      tag_q       <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      word_q      <= word_d;
      wcnt_q      <= wcnt_d;
      overrun_q   <= overrun_d;
      ram_addr_q  <= ram_addr_d;
      tag_q       <= tag_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign sprite_index = busy ? IDX_W'(slot_q) : IDX_W'(NUM_SPRITES);
  assign sprite_word  = word_q;
  assign ram_addr     = ram_addr_d;
  assign cpu_rvalid   = tag_q[RAM_LAT-1];
  assign cpu_rdata    = cpu_rdata_d;
  assign fetch_busy   = busy;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Directed bench for sprite_fetch_sched: line fetch timing, RAM data alignment,
// CPU arbitration, overrun handling and mid-fetch reset.
module tb_sprite_fetch_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] pix_col;
  logic [4:0]  sprite_index;
  logic        sprite_word;
  logic [11:0] vid_addr;
  logic [1:0]  sprite_dvalid;
  logic [11:0] ram_addr;
  logic [31:0] ram_rdata;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        fetch_busy;
  logic        overrun;
  logic        overrun_clr;

  sprite_fetch_sched dut (
    .clk(clk), .resetn(resetn), .pix_col(pix_col),
    .sprite_index(sprite_index), .sprite_word(sprite_word), .vid_addr(vid_addr),
    .sprite_dvalid(sprite_dvalid), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .fetch_busy(fetch_busy),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  // sprite_man stand-in and a 2-cycle RAM returning a tagged copy of the address
  logic [11:0] a1, a2;
  always @(posedge clk) begin
    a1 <= ram_addr;
    a2 <= a1;
  end
  assign ram_rdata = {20'h5A5A5, a2};
  assign vid_addr  = {6'b0, sprite_index, sprite_word};

  int tests = 0;
  int fails = 0;
  bit ev1 = 0, ev2 = 0, cur_gnt = 0, exp_ovr = 0;
  logic [11:0] ea1 = '0, ea2 = '0, cur_addr = '0, exp_ram = '0;
  int dv_cnt = 0, gnt_low = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at pix_col=%0d", tag, obs, exp, pix_col);
    end
  endtask

  task automatic adv(input logic [11:0] col);
    @(posedge clk);
    #1;
    ev2 = ev1; ea2 = ea1;
    ev1 = cur_gnt; ea1 = cur_addr;
    cur_gnt = 1'b0;
    pix_col = col;
    cpu_addr = {4'h8, col[7:0]};
  endtask

  task automatic run_cols(input int start, input int n, input bit req, input bit fetch_on);
    int col;
    col = start;
    for (int i = 0; i < n; i++) begin
      int k, ph, w, slot, wd;
      bit in_win, issue;
      logic [1:0] exp_dv;
      adv(12'(col));
      cpu_req = req;
      in_win = fetch_on && col >= 704 && col <= 799;
      k = col - 704; ph = k % 3; w = k / 3; slot = w / 2; wd = w % 2;
      exp_dv = (in_win && ph == 2) ? ((wd == 1) ? 2'b10 : 2'b01) : 2'b00;
      issue = in_win && ph == 0;
      cur_gnt = req && !issue;
      cur_addr = cpu_addr;
      if (issue) exp_ram = {6'b0, 5'(slot), 1'(wd)};
      else if (cur_gnt) exp_ram = cpu_addr;
      #2;
      chk("busy", 32'(fetch_busy), 32'(in_win));
      chk("index", 32'(sprite_index), in_win ? 32'(slot) : 32'd16);
      if (in_win) chk("word", 32'(sprite_word), 32'(wd));
      chk("dvalid", 32'(sprite_dvalid), 32'(exp_dv));
      if (exp_dv != 2'b00) begin
        dv_cnt++;
        chk("rdata_vid", ram_rdata, {20'h5A5A5, 6'b0, 5'(slot), 1'(wd)});
      end
      chk("gnt", 32'(cpu_gnt), 32'(cur_gnt));
      chk("ram_addr", 32'(ram_addr), 32'(exp_ram));
      chk("rvalid", 32'(cpu_rvalid), 32'(ev2));
      if (ev2) chk("cpu_rdata", cpu_rdata, {20'h5A5A5, ea2});
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      if (in_win && req && cpu_gnt === 1'b0) gnt_low++;
      col = (col == 799) ? 0 : col + 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; pix_col = '0; cpu_req = 1'b0; cpu_addr = '0; overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_index", 32'(sprite_index), 32'd16);
    chk("rst_word", 32'(sprite_word), 32'd0);
    chk("rst_dvalid", 32'(sprite_dvalid), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1; resetn = 1'b1;

    // free-running line, no CPU traffic
    dv_cnt = 0;
    run_cols(690, 116, 1'b0, 1'b1);
    chk("dv_count_line1", 32'(dv_cnt), 32'd32);

    // CPU request held across the whole window
    gnt_low = 0;
    run_cols(690, 116, 1'b1, 1'b1);
    chk("gnt_low_cycles", 32'(gnt_low), 32'd32);
    run_cols(6, 4, 1'b0, 1'b1);

    // overrun: jump 750 -> 0 on what would have been a dvalid cycle
    run_cols(700, 51, 1'b0, 1'b1);
    adv(12'd0); #2;
    chk("ovr_drop_dvalid", 32'(sprite_dvalid), 32'd0);
    chk("ovr_busy_at_wrap", 32'(fetch_busy), 32'd1);
    adv(12'd1); #2;
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_idle", 32'(fetch_busy), 32'd0);
    chk("ovr_index", 32'(sprite_index), 32'd16);
    exp_ovr = 1'b1;
    run_cols(2, 5, 1'b0, 1'b1);
    adv(12'd7); overrun_clr = 1'b1; #2;
    chk("ovr_clr_same_cycle", 32'(overrun), 32'd1);
    adv(12'd8); overrun_clr = 1'b0; #2;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    exp_ovr = 1'b0;

    // set and clear in the same cycle: set wins
    run_cols(700, 51, 1'b0, 1'b1);
    adv(12'd0); overrun_clr = 1'b1; #2;
    chk("ovr2_drop_dvalid", 32'(sprite_dvalid), 32'd0);
    adv(12'd1); overrun_clr = 1'b0; #2;
    chk("ovr_set_beats_clr", 32'(overrun), 32'd1);
    adv(12'd2); overrun_clr = 1'b1;
    adv(12'd3); overrun_clr = 1'b0; #2;
    chk("ovr2_cleared", 32'(overrun), 32'd0);

    // reset pulse mid-fetch at column 720
    run_cols(700, 21, 1'b0, 1'b1);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_index", 32'(sprite_index), 32'd16);
    chk("mid_rst_word", 32'(sprite_word), 32'd0);
    chk("mid_rst_dvalid", 32'(sprite_dvalid), 32'd0);
    chk("mid_rst_busy", 32'(fetch_busy), 32'd0);
    chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("mid_rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("mid_rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    exp_ram = '0;
    @(posedge clk); #1;
    resetn = 1'b1; pix_col = 12'd721;
    ev1 = 1'b0; ev2 = 1'b0; cur_gnt = 1'b0;
    run_cols(722, 78, 1'b0, 1'b0);
    dv_cnt = 0;
    run_cols(0, 806, 1'b0, 1'b1);
    chk("dv_count_after_rst", 32'(dv_cnt), 32'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
